// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS control FSM (master) and its
// datapath (slave): the opcode/ready inputs and every strobe and mux select.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pcwrite;
  logic       pcwritecond;
  logic       branch_ne;
  logic       iord;
  logic       memread;
  logic       memwrite;
  logic       irwrite;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic [1:0] pcsrc;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;

  modport master (
    input  opcode, mem_ready,
    output pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc, state,
           instr_done, illegal_op, mem_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pcwrite, pcwritecond, branch_ne, iord, memread, memwrite, irwrite,
           memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc, state,
           instr_done, illegal_op, mem_timeout
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback with a
// memory-wait watchdog. Define MC_BNE_EN to accept BNE (opcode 000101).
module mc_ctrl_fsm #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mc_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [5:0]       r_op;

  logic       w_wait_st;
  logic       w_timeout;
  logic       w_pcwrite;
  logic       w_pcwritecond;
  logic       w_branch_ne;
  logic       w_iord;
  logic       w_memread;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_memtoreg;
  logic       w_regdst;
  logic       w_regwrite;
  logic       w_alusrca;
  logic [1:0] w_alusrcb;
  logic [1:0] w_aluop;
  logic [1:0] w_pcsrc;
  logic       w_instr_done;
  logic       w_illegal_op;
  logic       w_mem_timeout;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MC_BNE_EN
      OP_BNE:                                        ok = 1'b1;
`endif
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Only FETCH, MEMRD and MEMWR wait on memory; ready on the limit cycle wins.
  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = w_wait_st && !bus.mem_ready && (r_cnt == CNT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
    end else begin
      if (w_wait_st && !bus.mem_ready && !w_timeout)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;

      case (r_state)
        S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          case (bus.opcode)
            OP_RTYPE:      r_state <= S_EXECUTE;
            OP_LW, OP_SW:  r_state <= S_MEMADR;
            OP_BEQ:        r_state <= S_BRANCH;
`ifdef MC_BNE_EN
            OP_BNE:        r_state <= S_BRANCH;
`endif
            OP_ADDI:       r_state <= S_ADDIEX;
            OP_J:          r_state <= S_JUMP;
            default:       r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD: begin
          if (bus.mem_ready)  r_state <= S_MEMWB;
          else if (w_timeout) r_state <= S_FETCH;
        end
        S_MEMWR:   if (bus.mem_ready || w_timeout) r_state <= S_FETCH;
        S_EXECUTE: r_state <= S_ALUWB;
        S_ADDIEX:  r_state <= S_ADDIWB;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // Opcode captured in DECODE steers MEMADR and the BNE condition later on.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) r_op <= bus.opcode;
  end

  // Moore/Mealy output decode; everything is forced low while reset is held.
  always_comb begin
    w_pcwrite     = 1'b0;
    w_pcwritecond = 1'b0;
    w_branch_ne   = 1'b0;
    w_iord        = 1'b0;
    w_memread     = 1'b0;
    w_memwrite    = 1'b0;
    w_irwrite     = 1'b0;
    w_memtoreg    = 1'b0;
    w_regdst      = 1'b0;
    w_regwrite    = 1'b0;
    w_alusrca     = 1'b0;
    w_alusrcb     = 2'b00;
    w_aluop       = 2'b00;
    w_pcsrc       = 2'b00;
    w_instr_done  = 1'b0;
    w_illegal_op  = 1'b0;
    w_mem_timeout = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_FETCH: begin
          w_memread     = 1'b1;
          w_alusrcb     = 2'b01;
          w_irwrite     = bus.mem_ready;
          w_pcwrite     = bus.mem_ready;
          w_mem_timeout = w_timeout;
        end
        S_DECODE: begin
          w_alusrcb    = 2'b11;
          w_illegal_op = !op_legal(bus.opcode);
        end
        S_MEMADR: begin
          w_alusrca = 1'b1;
          w_alusrcb = 2'b10;
        end
        S_MEMRD: begin
          w_iord        = 1'b1;
          w_memread     = 1'b1;
          w_mem_timeout = w_timeout;
        end
        S_MEMWB: begin
          w_memtoreg   = 1'b1;
          w_regwrite   = 1'b1;
          w_instr_done = 1'b1;
        end
        S_MEMWR: begin
          w_iord        = 1'b1;
          w_memwrite    = 1'b1;
          w_instr_done  = bus.mem_ready;
          w_mem_timeout = w_timeout;
        end
        S_EXECUTE: begin
          w_alusrca = 1'b1;
          w_aluop   = 2'b10;
        end
        S_ALUWB: begin
          w_regdst     = 1'b1;
          w_regwrite   = 1'b1;
          w_instr_done = 1'b1;
        end
        S_BRANCH: begin
          w_alusrca     = 1'b1;
          w_aluop       = 2'b01;
          w_pcwritecond = 1'b1;
          w_pcsrc       = 2'b01;
          w_instr_done  = 1'b1;
`ifdef MC_BNE_EN
          w_branch_ne   = (r_op == OP_BNE);
`else
          w_branch_ne   = 1'b0;
`endif
        end
        S_ADDIEX: begin
          w_alusrca = 1'b1;
          w_alusrcb = 2'b10;
        end
        S_ADDIWB: begin
          w_regwrite   = 1'b1;
          w_instr_done = 1'b1;
        end
        S_JUMP: begin
          w_pcwrite    = 1'b1;
          w_pcsrc      = 2'b10;
          w_instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pcwrite     = w_pcwrite;
  assign bus.pcwritecond = w_pcwritecond;
  assign bus.branch_ne   = w_branch_ne;
  assign bus.iord        = w_iord;
  assign bus.memread     = w_memread;
  assign bus.memwrite    = w_memwrite;
  assign bus.irwrite     = w_irwrite;
  assign bus.memtoreg    = w_memtoreg;
  assign bus.regdst      = w_regdst;
  assign bus.regwrite    = w_regwrite;
  assign bus.alusrca     = w_alusrca;
  assign bus.alusrcb     = w_alusrcb;
  assign bus.aluop       = w_aluop;
  assign bus.pcsrc       = w_pcsrc;
  assign bus.state       = r_state;
  assign bus.instr_done  = w_instr_done;
  assign bus.illegal_op  = w_illegal_op;
  assign bus.mem_timeout = w_mem_timeout;

endmodule
